// File: rtl/mem_stage_if.sv
// Bundle of EX->MEM->WB handshake, payload, data-SRAM response and flush signals.
// The slave modport belongs to mem_stage. The master modport belongs to the surrounding pipeline.
interface mem_stage_if;
    logic        ex_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] ex_pc;
    logic        ex_gr_we;
    logic [4:0]  ex_dest;
    logic [31:0] ex_result;
    logic [2:0]  ex_load_op;
    logic        ex_mem_req;
    logic        ex_exc;
    logic [5:0]  ex_ecode;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_to_wb_valid;
    logic        wb_allowin;
    logic [31:0] mem_pc;
    logic        mem_gr_we;
    logic [4:0]  mem_dest;
    logic [31:0] mem_final_result;
    logic        mem_exc;
    logic [5:0]  mem_ecode;
    logic [4:0]  mem_fwd_dest;
    logic [31:0] mem_fwd_data;
    logic        mem_fwd_stall;
    logic        flush;
    logic        mem_has_exc;

    modport slave (
        input  ex_to_mem_valid, ex_pc, ex_gr_we, ex_dest, ex_result, ex_load_op,
               ex_mem_req, ex_exc, ex_ecode, data_sram_data_ok, data_sram_rdata,
               wb_allowin, flush,
        output mem_allowin, mem_to_wb_valid, mem_pc, mem_gr_we, mem_dest,
               mem_final_result, mem_exc, mem_ecode, mem_fwd_dest, mem_fwd_data,
               mem_fwd_stall, mem_has_exc
    );

    modport master (
        output ex_to_mem_valid, ex_pc, ex_gr_we, ex_dest, ex_result, ex_load_op,
               ex_mem_req, ex_exc, ex_ecode, data_sram_data_ok, data_sram_rdata,
               wb_allowin, flush,
        input  mem_allowin, mem_to_wb_valid, mem_pc, mem_gr_we, mem_dest,
               mem_final_result, mem_exc, mem_ecode, mem_fwd_dest, mem_fwd_data,
               mem_fwd_stall, mem_has_exc
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns and extends load data, and forwards results.
// Also holds late responses when WB stalls and drops responses that belong to flushed loads.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  bus
);

    typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_READY} state_e;

    state_e      state_q;
    logic        discard_q;
    logic [31:0] hold_q;
    logic [31:0] pc_q;
    logic        gr_we_q;
    logic [4:0]  dest_q;
    logic [31:0] result_q;
    logic [2:0]  load_op_q;
    logic        exc_q;
    logic [5:0]  ecode_q;

    logic        valid;
    logic        ready_go;
    logic        allowin;
    logic        accept;
    logic        handoff;
    logic [31:0] src;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] final_result;

    assign valid    = (state_q != ST_EMPTY);
    assign ready_go = (state_q == ST_READY) ||
                      ((state_q == ST_WAIT) && bus.data_sram_data_ok);
    assign allowin  = !discard_q && (!valid || (ready_go && bus.wb_allowin));
    assign accept   = bus.ex_to_mem_valid && allowin && !bus.flush;
    assign handoff  = valid && ready_go && bus.wb_allowin;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_EMPTY;
            discard_q <= 1'b0;
            hold_q    <= '0;
            pc_q      <= '0;
            gr_we_q   <= 1'b0;
            dest_q    <= '0;
            result_q  <= '0;
            load_op_q <= '0;
            exc_q     <= 1'b0;
            ecode_q   <= '0;
        end else begin
            // A pending discard survives a flush of an empty stage; only a response clears it.
            discard_q <= discard_q && !bus.data_sram_data_ok;
            if (bus.flush) begin
                state_q <= ST_EMPTY;
                if ((state_q == ST_WAIT) && !bus.data_sram_data_ok)
                    discard_q <= 1'b1;
            end else if (accept) begin
                pc_q      <= bus.ex_pc;
                gr_we_q   <= bus.ex_gr_we;
                dest_q    <= bus.ex_dest;
                result_q  <= bus.ex_result;
                load_op_q <= bus.ex_load_op;
                exc_q     <= bus.ex_exc;
                ecode_q   <= bus.ex_ecode;
                state_q   <= bus.ex_mem_req ? ST_WAIT : ST_READY;
            end else if (handoff) begin
                state_q <= ST_EMPTY;
            end else if ((state_q == ST_WAIT) && bus.data_sram_data_ok) begin
                hold_q  <= bus.data_sram_rdata;
                state_q <= ST_READY;
            end
        end
    end

    always_comb begin
        src = (state_q == ST_WAIT) ? bus.data_sram_rdata : hold_q;
        case (result_q[1:0])
            2'd0:    byte_sel = src[7:0];
            2'd1:    byte_sel = src[15:8];
            2'd2:    byte_sel = src[23:16];
            default: byte_sel = src[31:24];
        endcase
        half_sel = result_q[1] ? src[31:16] : src[15:0];
        case (load_op_q)
            3'b001:  final_result = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  final_result = {24'h0, byte_sel};
            3'b011:  final_result = {{16{half_sel[15]}}, half_sel};
            3'b100:  final_result = {16'h0, half_sel};
            3'b101:  final_result = src;
            default: final_result = result_q;
        endcase
    end

    assign bus.mem_allowin      = allowin;
    assign bus.mem_to_wb_valid  = valid && ready_go && !bus.flush;
    assign bus.mem_pc           = pc_q;
    assign bus.mem_gr_we        = gr_we_q;
    assign bus.mem_dest         = dest_q;
    assign bus.mem_final_result = final_result;
    assign bus.mem_exc          = exc_q;
    assign bus.mem_ecode        = ecode_q;
    assign bus.mem_fwd_dest     = (valid && gr_we_q) ? dest_q : 5'd0;
    assign bus.mem_fwd_data     = final_result;
    assign bus.mem_fwd_stall    = valid && (load_op_q != 3'b000) && !ready_go;
    assign bus.mem_has_exc      = valid && exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage. A slot-level reference model is checked against the DUT on every cycle.
// Hand-computed literal expectations pin the model at key points.
module tb_mem_stage;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_stage_if bus ();
    mem_stage dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // occ: instruction present; owed: response still outstanding; data: captured response
    typedef struct packed {
        logic        occ;
        logic        owed;
        logic [31:0] data;
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [2:0]  op;
        logic        exc;
        logic [5:0]  ecode;
        logic [7:0]  drops;
    } model_t;

    model_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] w, input logic [31:0] res);
        logic [31:0] bv;
        logic [31:0] hv;
        bv = (w >> (8 * (addr % 4))) & 32'hFF;
        hv = (w >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (op)
            3'd1:    return (bv >= 32'd128) ? bv - 32'd256 : bv;
            3'd2:    return bv;
            3'd3:    return (hv >= 32'd32768) ? hv - 32'd65536 : hv;
            3'd4:    return hv;
            3'd5:    return w;
            default: return res;
        endcase
    endfunction

    function automatic model_t step_model(input model_t cur, input logic rst_n);
        model_t n;
        logic have;
        logic allow;
        n = cur;
        if (!rst_n) return '0;
        have  = cur.occ && (!cur.owed || bus.data_sram_data_ok);
        allow = (cur.drops == 0) && (!cur.occ || (have && bus.wb_allowin));
        if (bus.data_sram_data_ok && cur.drops != 0) n.drops = cur.drops - 8'd1;
        if (bus.flush) begin
            if (cur.occ && cur.owed && !bus.data_sram_data_ok) n.drops = n.drops + 8'd1;
            n.occ = 1'b0;
        end else begin
            if (cur.occ && have && bus.wb_allowin) n.occ = 1'b0;
            else if (cur.occ && cur.owed && bus.data_sram_data_ok) begin
                n.owed = 1'b0;
                n.data = bus.data_sram_rdata;
            end
            if (bus.ex_to_mem_valid && allow) begin
                n.occ    = 1'b1;
                n.owed   = bus.ex_mem_req;
                n.pc     = bus.ex_pc;
                n.gr_we  = bus.ex_gr_we;
                n.dest   = bus.ex_dest;
                n.result = bus.ex_result;
                n.op     = bus.ex_load_op;
                n.exc    = bus.ex_exc;
                n.ecode  = bus.ex_ecode;
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= step_model(m, resetn);

    always @(negedge clk) begin
        if (chk_en) begin
            logic have;
            logic [31:0] w;
            have = m.occ && (!m.owed || bus.data_sram_data_ok);
            w = m.owed ? bus.data_sram_rdata : m.data;
            chk("allowin", {31'd0, bus.mem_allowin},
                {31'd0, (m.drops == 0) && (!m.occ || (have && bus.wb_allowin))});
            chk("to_wb_valid", {31'd0, bus.mem_to_wb_valid}, {31'd0, have && !bus.flush});
            chk("fwd_stall", {31'd0, bus.mem_fwd_stall}, {31'd0, m.occ && m.op != 0 && !have});
            chk("fwd_dest", {27'd0, bus.mem_fwd_dest}, {27'd0, (m.occ && m.gr_we) ? m.dest : 5'd0});
            chk("has_exc", {31'd0, bus.mem_has_exc}, {31'd0, m.occ && m.exc});
            chk("pc", bus.mem_pc, m.pc);
            chk("gr_we", {31'd0, bus.mem_gr_we}, {31'd0, m.gr_we});
            chk("dest", {27'd0, bus.mem_dest}, {27'd0, m.dest});
            chk("exc", {31'd0, bus.mem_exc}, {31'd0, m.exc});
            chk("ecode", {26'd0, bus.mem_ecode}, {26'd0, m.ecode});
            if (m.occ) begin
                chk("final", bus.mem_final_result, model_load(m.op, m.result, w, m.result));
                chk("fwd_data", bus.mem_fwd_data, model_load(m.op, m.result, w, m.result));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] dest,
                       input logic [31:0] res, input logic [2:0] op, input logic req,
                       input logic exc, input logic [5:0] ecode);
        bus.ex_to_mem_valid = v;
        bus.ex_pc      = pc;
        bus.ex_gr_we   = we;
        bus.ex_dest    = dest;
        bus.ex_result  = res;
        bus.ex_load_op = op;
        bus.ex_mem_req = req;
        bus.ex_exc     = exc;
        bus.ex_ecode   = ecode;
    endtask

    task automatic resp(input logic ok, input logic [31:0] data);
        bus.data_sram_data_ok = ok;
        bus.data_sram_rdata   = data;
    endtask

    typedef struct packed {
        logic [2:0]  op;
        logic [1:0]  a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{3'd1, 2'd0, 32'h0000_007E};
        vecs[1] = '{3'd1, 2'd1, 32'hFFFF_FFF0};
        vecs[2] = '{3'd2, 2'd1, 32'h0000_00F0};
        vecs[3] = '{3'd2, 2'd3, 32'h0000_0084};
        vecs[4] = '{3'd3, 2'd0, 32'hFFFF_F07E};
        vecs[5] = '{3'd3, 2'd2, 32'hFFFF_8421};
        vecs[6] = '{3'd4, 2'd0, 32'h0000_F07E};
        vecs[7] = '{3'd5, 2'd2, 32'h8421_F07E};
        vecs[8] = '{3'd6, 2'd1, 32'h0000_4001};
        vecs[9] = '{3'd7, 2'd3, 32'h0000_4003};

        resetn = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        resp(0, 0);
        bus.wb_allowin = 1'b1;
        bus.flush = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_allowin", {31'd0, bus.mem_allowin}, 32'd1);
        chk("rst_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);
        chk("rst_final", bus.mem_final_result, 32'd0);
        chk("rst_fwd_dest", {27'd0, bus.mem_fwd_dest}, 32'd0);
        resetn = 1'b1;
        tick();

        // ld.b at byte 3 with the response arriving while WB accepts
        put(1, 32'h100, 1, 5'd5, 32'h1003, 3'd1, 1, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("ldb_stall", {31'd0, bus.mem_fwd_stall}, 32'd1);
        tick();
        resp(1, 32'h80FF_1234);
        #1 chk("ldb_final", bus.mem_final_result, 32'hFFFF_FF80);
        chk("ldb_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        tick();
        resp(0, 0);

        // ld.hu whose response is held while WB stalls for three cycles
        put(1, 32'h104, 1, 5'd6, 32'h2002, 3'd4, 1, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.wb_allowin = 1'b0;
        resp(1, 32'h8001_0000);
        #1 chk("ldhu_allowin", {31'd0, bus.mem_allowin}, 32'd0);
        tick();
        resp(0, 32'hFFFF_FFFF);
        #1 chk("ldhu_stall", {31'd0, bus.mem_fwd_stall}, 32'd0);
        chk("ldhu_held", bus.mem_final_result, 32'h0000_8001);
        tick();
        tick();
        bus.wb_allowin = 1'b1;
        #1 chk("ldhu_handoff", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        chk("ldhu_final", bus.mem_final_result, 32'h0000_8001);
        tick();

        // flush while waiting: the late response must be dropped
        put(1, 32'h108, 1, 5'd7, 32'h3000, 3'd5, 1, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1 chk("fl_allowin1", {31'd0, bus.mem_allowin}, 32'd0);
        tick();
        resp(1, 32'hDEAD_BEEF);
        #1 chk("fl_allowin2", {31'd0, bus.mem_allowin}, 32'd0);
        chk("fl_novalid", {31'd0, bus.mem_to_wb_valid}, 32'd0);
        tick();
        resp(0, 0);
        #1 chk("fl_cleared", {31'd0, bus.mem_allowin}, 32'd1);

        // ALU op followed back to back by ld.w
        put(1, 32'h200, 1, 5'd3, 32'h1234, 3'd0, 0, 0, 0);
        tick();
        put(1, 32'h204, 1, 5'd9, 32'h3000, 3'd5, 1, 0, 0);
        #1 chk("b2b_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        chk("b2b_fwd_dest", {27'd0, bus.mem_fwd_dest}, 32'd3);
        chk("b2b_final", bus.mem_final_result, 32'h1234);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("b2b_stall", {31'd0, bus.mem_fwd_stall}, 32'd1);
        tick();
        resp(1, 32'hCAFE_F00D);
        #1 chk("b2b_ldw", bus.mem_final_result, 32'hCAFE_F00D);
        tick();
        resp(0, 0);

        // exception instruction is ready at once
        bus.wb_allowin = 1'b0;
        put(1, 32'h300, 0, 5'd0, 32'h0, 3'd0, 0, 1, 6'h09);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("exc_has", {31'd0, bus.mem_has_exc}, 32'd1);
        chk("exc_ecode", {26'd0, bus.mem_ecode}, 32'h09);
        chk("exc_valid", {31'd0, bus.mem_to_wb_valid}, 32'd1);
        tick();
        bus.wb_allowin = 1'b1;
        tick();

        // flush concurrent with the response leaves nothing to discard
        put(1, 32'h400, 1, 5'd4, 32'h10, 3'd5, 1, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush = 1'b1;
        resp(1, 32'h1111_2222);
        tick();
        bus.flush = 1'b0;
        resp(0, 0);
        #1 chk("flok_allowin", {31'd0, bus.mem_allowin}, 32'd1);
        tick();

        // flush again while a discard is pending and the stage is empty
        put(1, 32'h500, 1, 5'd4, 32'h10, 3'd5, 1, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush = 1'b1;
        tick();
        tick();
        bus.flush = 1'b0;
        #1 chk("fl2_allowin", {31'd0, bus.mem_allowin}, 32'd0);
        tick();
        resp(1, 32'h5555_AAAA);
        tick();
        resp(0, 0);
        #1 chk("fl2_cleared", {31'd0, bus.mem_allowin}, 32'd1);

        // load-extension table; odd entries see WB stall at response time
        for (int i = 0; i < 10; i++) begin
            put(1, 32'h600 + 32'(i * 4), 1, 5'(i + 10), 32'h4000 + {30'd0, vecs[i].a},
                vecs[i].op, 1, 0, 0);
            tick();
            put(0, 0, 0, 0, 0, 0, 0, 0, 0);
            bus.wb_allowin = (i % 2 == 0);
            resp(1, 32'h8421_F07E);
            if (i % 2 == 0) begin
                #1 chk("tbl_final", bus.mem_final_result, vecs[i].exp);
                tick();
                resp(0, 0);
            end else begin
                tick();
                resp(0, 0);
                #1 chk("tbl_held", bus.mem_final_result, vecs[i].exp);
                bus.wb_allowin = 1'b1;
                tick();
            end
        end

        // reset mid-wait abandons the response without discard tracking
        put(1, 32'h700, 1, 5'd8, 32'h20, 3'd5, 1, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        resp(1, 32'h7777_7777);
        #1 chk("rstw_allowin", {31'd0, bus.mem_allowin}, 32'd1);
        chk("rstw_valid", {31'd0, bus.mem_to_wb_valid}, 32'd0);
        tick();
        resp(0, 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
